dmem_responder: RTL



---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_word_array.sv | 28 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Holds the FSM state type, the alignment mask and the counter sizing.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] DMEM_ALIGN_MASK = 2'b11;

  // The counter must hold the value WAIT_STATES and is never narrower than one bit.
  function automatic int dmem_cnt_w(input int ws);
    return (ws < 2) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word-addressed storage for the responder.
// Writes are synchronous, reads are combinational, and reset clears every word.
module dmem_word_array #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 256,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory interface: one outstanding request,
// a programmable wait, then a held response with read data and fault flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = dmem_cnt_w(WAIT_STATES);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(WAIT_STATES);
  localparam logic [WORD_SIZE-3:0] DEPTH_LIM = (WORD_SIZE-2)'(DEPTH);

  typedef struct packed {
    logic                 write;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } dmem_req_t;

  dmem_state_e          state;
  logic [CNT_W-1:0]     cnt;
  dmem_req_t            req_q;
  logic                 fault;
  logic                 last;
  logic                 arr_we;
  logic [IDX_W-1:0]     idx;
  logic [WORD_SIZE-1:0] rd_word;

  assign idx   = req_q.addr[2+IDX_W-1:2];
  assign fault = (|(req_q.addr[1:0] & DMEM_ALIGN_MASK)) ||
                 (req_q.addr[WORD_SIZE-1:2] >= DEPTH_LIM);
  // The wait counter spans WAIT_STATES idle cycles plus the access cycle,
  // so the response lands WAIT_STATES+1 edges after acceptance.
  assign last   = (cnt == CNT_LAST);
  assign arr_we = (state == DMEM_WAIT) && last && req_q.write && !fault;

  // Gated by rst so the port reads 0 throughout reset and 1 as soon as it drops.
  assign req_ready = (state == DMEM_IDLE) && !rst;

  dmem_word_array #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .idx   (idx),
    .wdata (req_q.wdata),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DMEM_IDLE;
      cnt        <= '0;
      req_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (req_valid && req_ready) begin
            req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            cnt   <= '0;
            state <= DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          if (last) begin
            cnt        <= '0;
            state      <= DMEM_RESP;
            resp_valid <= 1'b1;
            resp_err   <= fault;
            // Read happens before the write lands, so a load sees the old word.
            resp_rdata <= (req_q.write || fault) ? '0 : rd_word;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DMEM_RESP: begin
          if (resp_ready) begin
            state      <= DMEM_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end

endmodule
